// File: rtl/gate_scan_pkg.sv
// Shared definitions for the gate truth-table scanner: FSM encodings,
// legal parameter ranges and the settle-counter width.
package gate_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_t;

    localparam int N_IN_MIN   = 1;
    localparam int N_IN_MAX   = 4;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/and_gate.sv
// Two-input AND built from a 2:1 mux; the gate scanned in the bench.
module and_gate (
    input  logic a,
    input  logic b,
    output logic out
);

    assign out = a ? b : 1'b0;

endmodule

// File: rtl/scan_settle_cnt.sv
// 4-bit down-counter that times how long each vector is held before sampling.
// Load takes priority; the count stops at zero, where tc is asserted.
module scan_settle_cnt
    import gate_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_reg;

    // Count register: reload on request, otherwise decrement down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign tc = (cnt_reg == '0);

endmodule

// File: rtl/gate_truth_scanner.sv
// Sweeps every input combination onto a gate, waits SETTLE cycles per vector,
// samples gate_out and assembles the truth table.
// Optional checker (exp/match/first_bad) is built when GATE_SCAN_CHECK_EN is defined.
// The table port is named truth_table because "table" is a reserved word.
module gate_truth_scanner
    import gate_scan_pkg::*;
#(
    parameter  int N_IN   = 2,
    parameter  int SETTLE = 2,
    localparam int T      = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            gate_out,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic [T-1:0]    truth_table
`ifdef GATE_SCAN_CHECK_EN
    ,
    input  logic [T-1:0]    exp,
    output logic            match,
    output logic [N_IN-1:0] first_bad
`endif
);

    localparam logic [N_IN-1:0]  LAST_IDX = {N_IN{1'b1}};
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    scan_state_t     state_reg, state_next;
    logic [N_IN-1:0] index_reg;
    logic [T-1:0]    table_reg, table_next;
    logic            cnt_load, cnt_en, cnt_tc;
    logic            last_idx;

    assign last_idx = (index_reg == LAST_IDX);

    scan_settle_cnt u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .en       (cnt_en),
        .tc       (cnt_tc)
    );

    // Next-state and counter control.
    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_DRIVE;
                    cnt_load   = 1'b1;
                end
            end
            ST_DRIVE: begin
                cnt_en = 1'b1;
                if (cnt_tc) state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (last_idx) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_DRIVE;
                    cnt_load   = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Table with the current sample folded in; used for the write and the checker.
    always_comb begin
        table_next = table_reg;
        table_next[index_reg] = gate_out;
    end

    // State, index and table registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            index_reg <= '0;
            table_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        index_reg <= '0;
                        table_reg <= '0;
                    end
                end
                ST_SAMPLE: begin
                    table_reg <= table_next;
                    if (!last_idx) index_reg <= index_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign vec         = index_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign done        = (state_reg == ST_DONE);
    assign truth_table = table_reg;

`ifdef GATE_SCAN_CHECK_EN
    logic [T-1:0]    exp_reg;
    logic            match_reg;
    logic [N_IN-1:0] first_bad_reg;
    logic [T-1:0]    diff;
    logic [N_IN-1:0] first_bad_next;

    assign diff = table_next ^ exp_reg;

    // Lowest differing index; scanning downward leaves the smallest one.
    always_comb begin
        first_bad_next = '0;
        for (int i = T - 1; i >= 0; i--) begin
            if (diff[i]) first_bad_next = N_IN'(i);
        end
    end

    // Capture exp on acceptance and latch the verdict on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_reg       <= '0;
            match_reg     <= 1'b0;
            first_bad_reg <= '0;
        end else if ((state_reg == ST_IDLE) && start) begin
            exp_reg       <= exp;
            match_reg     <= 1'b0;
            first_bad_reg <= '0;
        end else if ((state_reg == ST_SAMPLE) && last_idx) begin
            match_reg     <= (diff == '0);
            first_bad_reg <= first_bad_next;
        end
    end

    assign match     = match_reg;
    assign first_bad = first_bad_reg;
`endif

endmodule

// File: doc/gate_truth_scanner.md
# gate_truth_scanner

Sequential stimulus and capture stage that sits directly upstream of the mux-built logic gates (and_gate and siblings). On a start request it sweeps every input combination onto the gate's inputs, waits a programmable settle time, samples the gate output, and assembles the complete truth table in a register. An optional checker compares the captured table against an expected pattern, so a gate can be verified in-circuit.

## Interface
- `N_IN`, default 2: number of gate inputs driven; legal range 1..4; table width `T = 2**N_IN`.
- `SETTLE`, default 2: cycles the vector is held before sampling; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a scan; sampled only in IDLE.
- `gate_out` in 1: output of the gate under scan.
- `vec` out N_IN: gate inputs; MSB drives input `a`, bit 0 drives the last input (for N_IN=2, `{a,b}`).
- `busy` out 1: high from the cycle after start acceptance through the DONE cycle.
- `done` out 1: one-cycle pulse when the table is complete.
- `table` out T: captured truth table; `table[i]` = `gate_out` observed with `vec == i`.
- `exp` in T (checker only): expected table, captured on start acceptance.
- `match` out 1 (checker only): table equals captured `exp`.
- `first_bad` out N_IN (checker only): lowest index where the tables differ; 0 when matched.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: `start=1` -> clear `table`, set index to 0, and go to DRIVE. Otherwise stay.
- DRIVE: `vec = index`; settle counter runs 0..SETTLE-1; on the last count go to SAMPLE.
- SAMPLE: `vec` is still held; write `table[index] <= gate_out`.
  - If `index == T-1`, go to DONE.
  - Otherwise increment `index` and go to DRIVE.
- DONE: `done=1` for exactly one cycle, then return to IDLE.
- `table` holds its value in IDLE until the next accepted start.
- `start` is ignored while `busy`. There is no queuing.
- `start` held high continuously produces back-to-back scans: the scan is re-accepted in the IDLE cycle that follows DONE.
- Index counter is `N_IN` bits wide; it never wraps mid-scan, because the exit is taken at `T-1`.
- `rst` mid-scan: the next state is IDLE, with all outputs at their reset values. The partial table is discarded and no `done` is produced.
- Reset values:
  - `vec=0`, `busy=0`, `done=0`, `table=0`.
  - Checker only: `match=0`, `first_bad=0`.

## Timing
- Start accepted at edge k (state IDLE, `start=1`): DRIVE for index 0 begins in cycle k+1.
- Each vector occupies SETTLE+1 cycles: SETTLE in DRIVE, then 1 in SAMPLE.
- `done` is high in cycle `k+1+T*(SETTLE+1)`. With the defaults this is k+13.
- `table[i]` is updated at the end of the SAMPLE cycle for index i. It is final, and the table is complete, in the DONE cycle.
- Checker outputs update at the transition into DONE and are valid in the DONE cycle. They hold until the next start acceptance, which clears them to 0.
- No combinational path from `gate_out` to any output. All outputs are registered.

## Configuration
- `GATE_SCAN_CHECK_EN`:
  - Defined: `exp`, `match` and `first_bad` exist, together with the `exp` capture register and comparison logic.
  - Undefined: those ports and that logic are absent. FSM, timing and `table` behaviour are identical in both builds.

## Structure
- Shared package/header `gate_scan_pkg`: FSM state encodings (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3), `N_IN`/`SETTLE` legal-range limits, and the settle-counter width (4 bits).
- One sub-module: `scan_settle_cnt`, a 4-bit down-counter with load/terminal-count, used by DRIVE.
- The gate under test stays outside. The bench instantiates and_gate and connects `vec[1]`->`a`, `vec[0]`->`b`, `out`->`gate_out`.

## Test plan
- AND gate, defaults, `start` pulsed at cycle 0 -> `vec` steps 0,1,2,3 every 3 cycles; `done` at cycle 13; `table=4'b1000`.
- Checker on, `exp=4'b1000` with and_gate -> `match=1`, `first_bad=0`. With `exp=4'b1001` -> `match=0`, `first_bad=0`. With `exp=4'b1100` -> `first_bad=2`.
- `start` re-pulsed while `busy` (cycle 5) -> ignored; single `done` at cycle 13; `table` unchanged by the extra pulse.
- `rst` asserted at cycle 7 mid-scan -> from cycle 8: `vec=0`, `busy=0`, `table=0`, and no `done` pulse.
- `N_IN=1`, `SETTLE=1`, `gate_out` tied to the inverse of `vec[0]` -> `table=2'b01`; `done` at cycle 5.
- `start` held high -> `done` every 14 cycles; `table` is cleared then rebuilt to `4'b1000` on each scan.
